// File: rtl/seq_scan_ctrl_if.sv
// Bundle of host/stream signals for the serial pattern-scan controller.
//   slave  : controller side (takes config/control/stream, drives status)
//   master : host/stream side
//   cfg_*        config offer/accept plus pattern, target and overlap mode
//   start/abort  run control pulses
//   bit_valid/bit_in  valid-qualified serial stream
//   match/match_cnt/busy/done  registered status back to the host
interface seq_scan_ctrl_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_overlap;
    logic             start;
    logic             abort;
    logic             bit_valid;
    logic             bit_in;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_target, cfg_overlap,
        input  start, abort, bit_valid, bit_in,
        output cfg_ready, match, match_cnt, busy, done
    );

    modport master (
        output cfg_valid, cfg_pattern, cfg_target, cfg_overlap,
        output start, abort, bit_valid, bit_in,
        input  cfg_ready, match, match_cnt, busy, done
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Run controller for serial bit-pattern detection.
// Holds a programmable pattern (MSB = first bit received), scans a valid-qualified
// serial stream while in SCAN, and counts matches in overlapping or non-overlapping
// mode. A non-zero target ends the run in DONE when the count reaches it.
// Ports:
//   clk  clock, all logic on posedge
//   rst  synchronous active-high reset (clears configuration too)
//   bus  seq_scan_ctrl_if.slave: config handshake, start/abort, stream, status
module seq_scan_ctrl #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_scan_ctrl_if.slave       bus
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             configured_q, configured_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             overlap_q, overlap_d;
    logic [PAT_W-1:0] window_q, window_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             cfg_xfer;
    logic [PAT_W-1:0] win_sh;
    logic [FW-1:0]    fill_inc;
    logic [CNT_W-1:0] cnt_inc;

    // cfg_ready is only ever high in IDLE/DONE, so a transfer implies one of those.
    assign cfg_xfer = bus.cfg_valid && cfg_ready_q;
    assign win_sh   = {window_q[PAT_W-2:0], bus.bit_in};
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    assign cnt_inc  = (&match_cnt_q) ? match_cnt_q : match_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        configured_d = configured_q;
        pattern_d    = pattern_q;
        target_d     = target_q;
        overlap_d    = overlap_q;
        window_d     = window_q;
        fill_d       = fill_q;
        match_d      = 1'b0;
        match_cnt_d  = match_cnt_q;

        if (cfg_xfer) begin
            configured_d = 1'b1;
            pattern_d    = bus.cfg_pattern;
            target_d     = bus.cfg_target;
            overlap_d    = bus.cfg_overlap;
        end

        case (state_q)
            S_IDLE: begin
                // A same-cycle config offer wins; the start is dropped.
                if (!cfg_xfer && bus.start && configured_q) begin
                    state_d     = S_SCAN;
                    window_d    = '0;
                    fill_d      = '0;
                    match_cnt_d = '0;
                end
            end
            S_SCAN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.bit_valid) begin
                    window_d = win_sh;
                    fill_d   = fill_inc;
                    if (fill_inc == FILL_FULL && win_sh == pattern_q) begin
                        match_d     = 1'b1;
                        match_cnt_d = cnt_inc;
                        // Non-overlap: the next match must be built from fresh bits.
                        if (!overlap_q) fill_d = '0;
                        if (target_q != '0 && cnt_inc == target_q) state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (cfg_xfer) begin
                    state_d = S_IDLE;
                end else if (bus.start && !bus.cfg_valid) begin
                    state_d     = S_SCAN;
                    window_d    = '0;
                    fill_d      = '0;
                    match_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d == S_SCAN);
        done_d      = (state_d == S_DONE);
        cfg_ready_d = (state_d != S_SCAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            configured_q <= 1'b0;
            pattern_q    <= '0;
            target_q     <= '0;
            overlap_q    <= 1'b0;
            window_q     <= '0;
            fill_q       <= '0;
            match_q      <= 1'b0;
            match_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            configured_q <= configured_d;
            pattern_q    <= pattern_d;
            target_q     <= target_d;
            overlap_q    <= overlap_d;
            window_q     <= window_d;
            fill_q       <= fill_d;
            match_q      <= match_d;
            match_cnt_q  <= match_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_ready = cfg_ready_q;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl. Bits that complete a match push the expected
// count into a queue; a monitor pops and compares on every match pulse.
module tb_seq_scan_ctrl;
    localparam int PAT_W = 5;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) mif ();
    seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(mif));

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every match pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (!rst && mif.match === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_match: got match_cnt %0d expected no match", mif.match_cnt);
            end else begin
                logic [CNT_W-1:0] e;
                e = exp_q.pop_front();
                if (mif.match_cnt !== e) begin
                    errors++;
                    $display("FAIL match_cnt_at_match: got %0d expected %0d", mif.match_cnt, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t, input logic ov);
        mif.cfg_valid = 1'b1; mif.cfg_pattern = p; mif.cfg_target = t; mif.cfg_overlap = ov;
        tick(1);
        mif.cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        mif.start = 1'b1; tick(1); mif.start = 1'b0;
    endtask

    task automatic do_abort();
        mif.abort = 1'b1; tick(1); mif.abort = 1'b0;
    endtask

    // push_cnt > 0: this bit completes a match yielding that count.
    task automatic send_bit(input logic b, input int push_cnt);
        if (push_cnt > 0) exp_q.push_back(CNT_W'(push_cnt));
        mif.bit_valid = 1'b1; mif.bit_in = b;
        tick(1);
        mif.bit_valid = 1'b0;
    endtask

    task automatic chk_drained(input string name);
        tick(1);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(2); rst = 1'b0;
    endtask

    logic [7:0] s1 [8] = '{1,1,0,1,1,0,1,1};

    initial begin
        mif.cfg_valid = 0; mif.cfg_pattern = '0; mif.cfg_target = '0; mif.cfg_overlap = 0;
        mif.start = 0; mif.abort = 0; mif.bit_valid = 0; mif.bit_in = 0;
        rst = 1'b1;
        tick(2);
        chk("rst_match", mif.match, 0);
        chk("rst_cnt", mif.match_cnt, 0);
        chk("rst_busy", mif.busy, 0);
        chk("rst_done", mif.done, 0);
        chk("rst_cfg_ready", mif.cfg_ready, 1);
        rst = 1'b0;
        tick(1);

        // 1: overlapping, unlimited
        do_cfg(5'b11011, 8'd0, 1'b1);
        do_start();
        chk("t1_busy", mif.busy, 1);
        chk("t1_cfg_ready", mif.cfg_ready, 0);
        for (int i = 0; i < 8; i++) send_bit(s1[i][0], (i == 4) ? 1 : (i == 7) ? 2 : 0);
        chk_drained("t1_drained");
        chk("t1_cnt", mif.match_cnt, 2);
        chk("t1_busy_end", mif.busy, 1);
        do_abort();
        chk("t1_abort_busy", mif.busy, 0);
        chk("t1_abort_cnt", mif.match_cnt, 2);

        // 2: non-overlapping
        do_cfg(5'b11011, 8'd0, 1'b0);
        do_start();
        for (int i = 0; i < 8; i++) send_bit(s1[i][0], (i == 4) ? 1 : 0);
        chk_drained("t2_drained");
        chk("t2_cnt", mif.match_cnt, 1);
        do_abort();

        // 3: target 2 ends the run
        do_cfg(5'b11011, 8'd2, 1'b1);
        do_start();
        for (int i = 0; i < 8; i++) send_bit(s1[i][0], (i == 4) ? 1 : (i == 7) ? 2 : 0);
        chk("t3_done", mif.done, 1);
        chk("t3_busy", mif.busy, 0);
        chk("t3_cfg_ready", mif.cfg_ready, 1);
        for (int i = 0; i < 5; i++) send_bit(s1[i][0], 0);
        chk_drained("t3_drained");
        chk("t3_cnt", mif.match_cnt, 2);
        do_cfg(5'b11011, 8'd0, 1'b1);
        chk("t3_cfg_done", mif.done, 0);
        chk("t3_cfg_cnt_kept", mif.match_cnt, 2);

        // 4: start without config, then cfg+start collision
        do_reset();
        do_start();
        chk("t4_noconfig_busy", mif.busy, 0);
        mif.cfg_valid = 1'b1; mif.cfg_pattern = 5'b11011; mif.cfg_target = 8'd0;
        mif.cfg_overlap = 1'b1; mif.start = 1'b1;
        tick(1);
        mif.cfg_valid = 1'b0; mif.start = 1'b0;
        chk("t4_collide_busy", mif.busy, 0);
        chk("t4_collide_ready", mif.cfg_ready, 1);

        // 5: abort mid-pattern, restart clears the window
        do_start();
        chk("t5_busy", mif.busy, 1);
        for (int i = 0; i < 4; i++) send_bit(s1[i][0], 0);
        do_abort();
        chk("t5_abort_busy", mif.busy, 0);
        chk("t5_abort_cnt", mif.match_cnt, 0);
        do_start();
        send_bit(1'b1, 0);
        chk_drained("t5_drained");
        chk("t5_cnt", mif.match_cnt, 0);
        do_abort();

        // 6: gaps between valid bits, then reset mid-run
        do_start();
        for (int i = 0; i < 5; i++) begin
            send_bit(s1[i][0], (i == 4) ? 1 : 0);
            tick(3);
        end
        chk_drained("t6_drained");
        chk("t6_cnt", mif.match_cnt, 1);
        chk("t6_busy", mif.busy, 1);
        do_reset();
        chk("t6_rst_busy", mif.busy, 0);
        chk("t6_rst_cnt", mif.match_cnt, 0);
        chk("t6_rst_ready", mif.cfg_ready, 1);
        do_start();
        chk("t6_rst_start_ignored", mif.busy, 0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
